pipe_ctrl: RTL

Central pipeline controller for the 3-stage core (if_id → id → id_ex → ex). It sequences holds and flushes of the PC, if_id and id_ex registers from three sources: branch/jump redirects out of ex, load-use hazards between id and id_ex, and multi-cycle ex operations (div/mul). An FSM covers multi-cycle flush and wait sequences, and a watchdog aborts hung multi-cycle operations.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_ctrl_hazard_detect.sv | 19 +
 rtl/pipe_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM state encoding,
// architectural zero constants and default sequencing parameters.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StFlush  = 2'd1,
        StMcWait = 2'd2
    } pctrl_state_e;

    localparam logic [4:0]  ZeroReg  = 5'd0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam int unsigned FlushCyclesDefault = 2;
    localparam int unsigned McTimeoutDefault   = 64;
    localparam int unsigned CntWDefault        = 7;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags when id reads a register that the
// load currently in id_ex has not yet written back.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic [4:0] idex_rd_addr_i,
    input  logic       idex_is_load_i,
    output logic       load_use_o
);

    always_comb begin
        load_use_o = idex_is_load_i
                   && (idex_rd_addr_i != ZeroReg)
                   && ((idex_rd_addr_i == id_rs1_addr_i) || (idex_rd_addr_i == id_rs2_addr_i));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: sequences PC/if_id/id_ex holds and flushes for redirects,
// load-use hazards and multi-cycle ex ops. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = FlushCyclesDefault,
    parameter int unsigned MC_TIMEOUT   = McTimeoutDefault,
    parameter int unsigned CNT_W        = CntWDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic [4:0]  idex_rd_addr_i,
    input  logic        idex_is_load_i,
    input  logic        mc_start_i,
    input  logic        mc_done_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        mc_abort_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FlushLast = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] McLast    = CNT_W'(MC_TIMEOUT - 1);

    pctrl_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;

    logic load_use;
    logic jump_en, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, mc_abort;

    hazard_detect u_hazard_detect (
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .idex_rd_addr_i (idex_rd_addr_i),
        .idex_is_load_i (idex_is_load_i),
        .load_use_o     (load_use)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        jump_en     = 1'b0;
        hold_pc     = 1'b0;
        hold_if_id  = 1'b0;
        hold_id_ex  = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        mc_abort    = 1'b0;

        unique case (state_q)
            StRun: begin
                if (jump_en_i) begin
                    jump_en     = 1'b1;
                    addr_d      = jump_addr_i;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = StFlush;
                        cnt_d   = CntOne;
                    end
                end else if (mc_start_i) begin
                    state_d = StMcWait;
                    cnt_d   = '0;
                end else if (load_use) begin
                    hold_pc     = 1'b1;
                    hold_if_id  = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end

            StFlush: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                if (jump_en_i) begin
                    // A fresh redirect restarts the flush window from its first cycle.
                    jump_en = 1'b1;
                    addr_d  = jump_addr_i;
                    cnt_d   = CntOne;
                end else if (cnt_q == FlushLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StMcWait: begin
                if (mc_done_i) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cnt_q == McLast) begin
                    mc_abort    = 1'b1;
                    flush_id_ex = 1'b1;
                    state_d     = StRun;
                    cnt_d       = '0;
                end else begin
                    hold_pc    = 1'b1;
                    hold_if_id = 1'b1;
                    hold_id_ex = 1'b1;
                    cnt_d      = cnt_q + CntOne;
                end
            end

            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is asserted; a flush beats a hold.
    always_comb begin
        jump_en_o     = !rst && jump_en;
        jump_addr_o   = rst ? ZeroWord : addr_d;
        hold_pc_o     = !rst && hold_pc;
        flush_if_id_o = !rst && flush_if_id;
        flush_id_ex_o = !rst && flush_id_ex;
        hold_if_id_o  = !rst && hold_if_id && !flush_if_id;
        hold_id_ex_o  = !rst && hold_id_ex && !flush_id_ex;
        mc_abort_o    = !rst && mc_abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
            addr_q  <= ZeroWord;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'd0, hold_pc_o};
            flush_cnt_q <= flush_cnt_q + {31'd0, flush_if_id_o};
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
